// File: rtl/arb_mux_n.sv
// N-input registered multiplexer with valid/ready on every channel.
// Arbitration is round-robin or fixed priority, with an optional forced-select bypass.
module arb_mux_n #(
    parameter int  DATA_WIDTH = 32,
    parameter int  NUM_IN     = 4,
    parameter int  ARB_MODE   = 0,
    localparam int SEL_W      = $clog2(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         force_en,
    input  logic [SEL_W-1:0]             force_sel,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]            in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]             out_sel,
    input  logic                         out_ready
);

    logic                  load;
    logic                  grant_ok;
    logic [SEL_W-1:0]      grant_idx;
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      ptr_inc;
    logic [DATA_WIDTH-1:0] grant_data;

    assign load = !out_valid || out_ready;

    always_comb begin : grant_logic
        int idx;
        grant_ok   = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        if (force_en) begin
            // An out-of-range force_sel matches no channel, so it simply yields no grant.
            for (int i = 0; i < NUM_IN; i++) begin
                if (force_sel == SEL_W'(i) && in_valid[i]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else if (ARB_MODE == 1) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NUM_IN) begin
                    idx = idx - NUM_IN;
                end
                if (!grant_ok && in_valid[idx]) begin
                    grant_ok  = 1'b1;
                    grant_idx = SEL_W'(idx);
                end
            end
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = rst_n && load && grant_ok && (grant_idx == SEL_W'(i));
        end
    end

    assign ptr_inc = (grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (grant_ok) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                // Forced transfers must not disturb round-robin fairness.
                if (ARB_MODE == 0 && !force_en) begin
                    ptr <= ptr_inc;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: round-robin and fixed-priority instances with four channels,
// plus a three-channel round-robin instance.
module tb_arb_mux_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // round-robin, 4 channels
    logic         rr_fen;
    logic [1:0]   rr_fsel;
    logic [3:0]   rr_valid;
    logic [127:0] rr_data;
    logic [3:0]   rr_ready;
    logic         rr_ovalid;
    logic [31:0]  rr_odata;
    logic [1:0]   rr_osel;
    logic         rr_oready;

    // fixed priority, 4 channels
    logic         fp_fen;
    logic [1:0]   fp_fsel;
    logic [3:0]   fp_valid;
    logic [127:0] fp_data;
    logic [3:0]   fp_ready;
    logic         fp_ovalid;
    logic [31:0]  fp_odata;
    logic [1:0]   fp_osel;
    logic         fp_oready;

    // round-robin, 3 channels
    logic         t3_fen;
    logic [1:0]   t3_fsel;
    logic [2:0]   t3_valid;
    logic [95:0]  t3_data;
    logic [2:0]   t3_ready;
    logic         t3_ovalid;
    logic [31:0]  t3_odata;
    logic [1:0]   t3_osel;
    logic         t3_oready;

    arb_mux_n #(.DATA_WIDTH(32), .NUM_IN(4), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .force_en(rr_fen), .force_sel(rr_fsel),
        .in_valid(rr_valid), .in_data(rr_data), .in_ready(rr_ready),
        .out_valid(rr_ovalid), .out_data(rr_odata), .out_sel(rr_osel), .out_ready(rr_oready)
    );

    arb_mux_n #(.DATA_WIDTH(32), .NUM_IN(4), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst_n(rst_n), .force_en(fp_fen), .force_sel(fp_fsel),
        .in_valid(fp_valid), .in_data(fp_data), .in_ready(fp_ready),
        .out_valid(fp_ovalid), .out_data(fp_odata), .out_sel(fp_osel), .out_ready(fp_oready)
    );

    arb_mux_n #(.DATA_WIDTH(32), .NUM_IN(3), .ARB_MODE(0)) u_t3 (
        .clk(clk), .rst_n(rst_n), .force_en(t3_fen), .force_sel(t3_fsel),
        .in_valid(t3_valid), .in_data(t3_data), .in_ready(t3_ready),
        .out_valid(t3_ovalid), .out_data(t3_odata), .out_sel(t3_osel), .out_ready(t3_oready)
    );

    task automatic set_defaults();
        rr_fen = 1'b0; rr_fsel = '0; rr_valid = '0; rr_oready = 1'b0;
        fp_fen = 1'b0; fp_fsel = '0; fp_valid = '0; fp_oready = 1'b0;
        t3_fen = 1'b0; t3_fsel = '0; t3_valid = '0; t3_oready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rr_data[i*32 +: 32] = 32'hA000_0000 | i;
            fp_data[i*32 +: 32] = 32'hB000_0000 | i;
        end
        for (int i = 0; i < 3; i++) begin
            t3_data[i*32 +: 32] = 32'hC000_0000 | i;
        end
    endtask

    task automatic do_reset();
        set_defaults();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        set_defaults();
        rr_valid = 4'hF;
        rr_oready = 1'b1;
        #1;
        checks++;
        if (rr_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0000", rr_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (rr_ovalid !== 1'b1 || rr_osel !== 2'd1) begin
            errors++; $display("FAIL reset_prestream: got valid=%b sel=%0d expected valid=1 sel=1", rr_ovalid, rr_osel);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rr_ovalid !== 1'b0 || rr_odata !== 32'h0 || rr_osel !== 2'd0) begin
            errors++; $display("FAIL reset_async: got valid=%b data=%h sel=%0d expected 0/0/0", rr_ovalid, rr_odata, rr_osel);
        end
        checks++;
        if (rr_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready_midstream: got %b expected 0000", rr_ready);
        end
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (rr_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant_ready: got %b expected 0001", rr_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rr_ovalid !== 1'b1 || rr_osel !== 2'd0 || rr_odata !== 32'hA000_0000) begin
            errors++; $display("FAIL reset_first_grant: got valid=%b sel=%0d data=%h expected 1/0/a0000000", rr_ovalid, rr_osel, rr_odata);
        end
    endtask

    task automatic test_rr_fairness();
        logic [1:0] exp_sel;
        do_reset();
        rr_valid = 4'hF;
        rr_oready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_sel = 2'(c % 4);
            #1;
            checks++;
            if (rr_ready !== (4'b0001 << exp_sel)) begin
                errors++; $display("FAIL rr_ready cycle %0d: got %b expected %b", c, rr_ready, 4'b0001 << exp_sel);
            end
            @(posedge clk); #1;
            checks++;
            if (rr_ovalid !== 1'b1 || rr_osel !== exp_sel || rr_odata !== (32'hA000_0000 | 32'(exp_sel))) begin
                errors++; $display("FAIL rr_out cycle %0d: got valid=%b sel=%0d data=%h expected sel=%0d", c, rr_ovalid, rr_osel, rr_odata, exp_sel);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        rr_data[2*32 +: 32] = 32'hDEAD_BEEF;
        rr_data[0*32 +: 32] = 32'h1111_1111;
        rr_valid = 4'b0100;
        #1;
        checks++;
        if (rr_ready !== 4'b0100) begin
            errors++; $display("FAIL bp_first_ready: got %b expected 0100", rr_ready);
        end
        @(posedge clk); #1;
        rr_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rr_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_stall_ready cycle %0d: got %b expected 0000", c, rr_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rr_ovalid !== 1'b1 || rr_odata !== 32'hDEAD_BEEF || rr_osel !== 2'd2) begin
                errors++; $display("FAIL bp_hold cycle %0d: got valid=%b data=%h sel=%0d expected 1/deadbeef/2", c, rr_ovalid, rr_odata, rr_osel);
            end
        end
        rr_oready = 1'b1;
        #1;
        checks++;
        if (rr_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_release_ready: got %b expected 0001", rr_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rr_ovalid !== 1'b1 || rr_odata !== 32'h1111_1111 || rr_osel !== 2'd0) begin
            errors++; $display("FAIL bp_no_bubble: got valid=%b data=%h sel=%0d expected 1/11111111/0", rr_ovalid, rr_odata, rr_osel);
        end
        rr_valid = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (rr_ovalid !== 1'b0 || rr_odata !== 32'h1111_1111 || rr_osel !== 2'd0) begin
            errors++; $display("FAIL bp_drain_hold: got valid=%b data=%h sel=%0d expected 0/11111111/0", rr_ovalid, rr_odata, rr_osel);
        end
    endtask

    task automatic test_force();
        do_reset();
        rr_oready = 1'b1;
        rr_valid = 4'b0001;
        @(posedge clk); #1;
        rr_fen = 1'b1;
        rr_fsel = 2'd3;
        rr_valid = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (rr_ready !== 4'b1000) begin
                errors++; $display("FAIL force_ready cycle %0d: got %b expected 1000", c, rr_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (rr_ovalid !== 1'b1 || rr_osel !== 2'd3 || rr_odata !== 32'hA000_0003) begin
                errors++; $display("FAIL force_out cycle %0d: got valid=%b sel=%0d data=%h expected 1/3/a0000003", c, rr_ovalid, rr_osel, rr_odata);
            end
        end
        rr_fsel = 2'd2;
        #1;
        checks++;
        if (rr_ready !== 4'b0000) begin
            errors++; $display("FAIL force_invalid_ready: got %b expected 0000", rr_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rr_ovalid !== 1'b0 || rr_osel !== 2'd3) begin
            errors++; $display("FAIL force_invalid_drain: got valid=%b sel=%0d expected 0/3", rr_ovalid, rr_osel);
        end
        // pointer was 1 before forcing; it must still be 1
        rr_fen = 1'b0;
        #1;
        checks++;
        if (rr_ready !== 4'b0010) begin
            errors++; $display("FAIL force_ptr_kept_ready: got %b expected 0010", rr_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rr_ovalid !== 1'b1 || rr_osel !== 2'd1) begin
            errors++; $display("FAIL force_ptr_kept: got valid=%b sel=%0d expected 1/1", rr_ovalid, rr_osel);
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        fp_oready = 1'b1;
        fp_valid = 4'b1100;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (fp_ready !== 4'b0100) begin
                errors++; $display("FAIL fp_ready cycle %0d: got %b expected 0100", c, fp_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (fp_ovalid !== 1'b1 || fp_osel !== 2'd2 || fp_odata !== 32'hB000_0002) begin
                errors++; $display("FAIL fp_out cycle %0d: got valid=%b sel=%0d data=%h expected 1/2/b0000002", c, fp_ovalid, fp_osel, fp_odata);
            end
        end
        fp_valid = 4'b1111;
        @(posedge clk); #1;
        checks++;
        if (fp_osel !== 2'd0 || fp_odata !== 32'hB000_0000) begin
            errors++; $display("FAIL fp_lowest_wins: got sel=%0d data=%h expected 0/b0000000", fp_osel, fp_odata);
        end
    endtask

    task automatic test_non_pow2();
        logic [1:0] exp_sel;
        do_reset();
        t3_oready = 1'b1;
        t3_valid = 3'b111;
        for (int c = 0; c < 5; c++) begin
            exp_sel = 2'(c % 3);
            #1;
            checks++;
            if (t3_ready !== (3'b001 << exp_sel)) begin
                errors++; $display("FAIL np2_ready cycle %0d: got %b expected %b", c, t3_ready, 3'b001 << exp_sel);
            end
            @(posedge clk); #1;
            checks++;
            if (t3_ovalid !== 1'b1 || t3_osel !== exp_sel || t3_odata !== (32'hC000_0000 | 32'(exp_sel))) begin
                errors++; $display("FAIL np2_out cycle %0d: got valid=%b sel=%0d data=%h expected sel=%0d", c, t3_ovalid, t3_osel, t3_odata, exp_sel);
            end
        end
        t3_fen = 1'b1;
        t3_fsel = 2'd3;
        #1;
        checks++;
        if (t3_ready !== 3'b000) begin
            errors++; $display("FAIL np2_force_oob_ready: got %b expected 000", t3_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (t3_ovalid !== 1'b0) begin
            errors++; $display("FAIL np2_force_oob_valid: got %b expected 0", t3_ovalid);
        end
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_backpressure();
        test_force();
        test_fixed_priority();
        test_non_pow2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
